// File: rtl/telemetry_tx_arbiter.sv
// telemetry_tx_arbiter
// Round-robin arbiter that shares one debug UART transmitter between several
// telemetry producers. The granted source's payload is latched and sent as a
// framed packet: SYNC, ID, payload bytes (MSB first), CHK. CHK is the running
// XOR of the ID byte and the payload bytes, accumulated as the bytes go out.

module telemetry_tx_arbiter #(
    parameter int         NUM_SRC       = 4,
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic                               clock,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 req,
    input  logic [NUM_SRC*PAYLOAD_BYTES*8-1:0] payload,
    output logic [NUM_SRC-1:0]                 grant,
    output logic                               tx_send,
    output logic [7:0]                         tx_data,
    input  logic                               tx_busy,
    output logic                               frame_active,
    output logic [15:0]                        frame_count
);

    localparam int FRAME_LEN = PAYLOAD_BYTES + 3;
    localparam int PW        = PAYLOAD_BYTES * 8;
    localparam int IDXW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW        = IDXW + 1;
    localparam int BIW       = $clog2(FRAME_LEN);

    localparam logic [BIW-1:0]  IDX_SYNC = BIW'(0);
    localparam logic [BIW-1:0]  IDX_ID   = BIW'(1);
    localparam logic [BIW-1:0]  IDX_LAST = BIW'(FRAME_LEN - 1);
    localparam logic [IDXW-1:0] SRC_LAST = IDXW'(NUM_SRC - 1);
    localparam logic [CW-1:0]   SRC_NUM  = CW'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Checksum accumulation step: XOR fold of one byte into the running value.
    function automatic logic [7:0] f_chk_fold(input logic [7:0] acc, input logic [7:0] b);
        f_chk_fold = acc ^ b;
    endfunction

    state_t            r_state;
    logic [IDXW-1:0]   r_last_grant;
    logic [IDXW-1:0]   r_winner;
    logic [PW-1:0]     r_payload;
    logic [BIW-1:0]    r_byte_idx;
    logic [7:0]        r_chk;

    logic              w_any;
    logic [IDXW-1:0]   w_winner;
    logic [CW-1:0]     w_cand;
    logic [NUM_SRC-1:0] w_grant_vec;
    logic [PW-1:0]     w_sel_payload;
    logic [7:0]        w_id;
    logic [7:0]        w_byte;
    logic [7:0]        w_chk_next;
    logic              w_is_payload;

    // Round-robin search: scan offsets from far to near so the nearest requester after last_grant wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_last_grant;
        w_cand   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_cand = {1'b0, r_last_grant} + CW'(k);
            if (w_cand >= SRC_NUM) begin
                w_cand = w_cand - SRC_NUM;
            end else begin
                w_cand = w_cand;
            end
            if (req[w_cand[IDXW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_cand[IDXW-1:0];
            end else begin
                w_any    = w_any;
            end
        end
    end

    // Winner decode: one-hot grant vector and the winner's payload slice.
    always_comb begin
        w_grant_vec   = '0;
        w_sel_payload = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_winner == IDXW'(i)) begin
                w_grant_vec[i] = 1'b1;
                w_sel_payload  = payload[i*PW +: PW];
            end else begin
                w_grant_vec[i] = 1'b0;
            end
        end
    end

    // Frame byte mux: picks the byte for the current index and the checksum after issuing it.
    always_comb begin
        w_id         = 8'(r_winner);
        w_byte       = 8'h00;
        w_chk_next   = r_chk;
        w_is_payload = 1'b0;
        if (r_byte_idx == IDX_SYNC) begin
            w_byte = SYNC_BYTE;
        end else if (r_byte_idx == IDX_ID) begin
            w_byte     = w_id;
            w_chk_next = f_chk_fold(r_chk, w_id);
        end else if (r_byte_idx == IDX_LAST) begin
            w_byte = r_chk;
        end else begin
            w_byte       = r_payload[PW-1 -: 8];
            w_chk_next   = f_chk_fold(r_chk, r_payload[PW-1 -: 8]);
            w_is_payload = 1'b1;
        end
    end

    // Frame sequencer: grant, byte issue over the send/busy handshake, frame bookkeeping.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= SRC_LAST;
            r_winner     <= '0;
            r_payload    <= '0;
            r_byte_idx   <= '0;
            r_chk        <= 8'h00;
            grant        <= '0;
            tx_send      <= 1'b0;
            tx_data      <= 8'h00;
            frame_active <= 1'b0;
            frame_count  <= 16'h0000;
        end else begin
            grant   <= '0;
            tx_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        grant        <= w_grant_vec;
                        r_winner     <= w_winner;
                        r_payload    <= w_sel_payload;
                        r_byte_idx   <= '0;
                        r_chk        <= 8'h00;
                        frame_active <= 1'b1;
                        r_state      <= ST_SEND;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    tx_send <= 1'b1;
                    tx_data <= w_byte;
                    r_chk   <= w_chk_next;
                    if (w_is_payload) begin
                        r_payload <= r_payload << 8;
                    end else begin
                        r_payload <= r_payload;
                    end
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // uart_tx may need this cycle to raise busy, so it is not looked at here
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (r_byte_idx == IDX_LAST) begin
                            frame_count  <= frame_count + 16'd1;
                            r_last_grant <= r_winner;
                            frame_active <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_byte_idx   <= r_byte_idx + BIW'(1);
                            r_state      <= ST_SEND;
                        end
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    frame_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/telemetry_tx_arbiter.md
# telemetry_tx_arbiter

Shares the single debug UART transmitter (the `uart_tx` driving the debug pin, 400 kbaud) between up to NUM_SRC telemetry producers (gyro samples, FPort decode status, motor commands, loop timing). It grants one requester at a time in round-robin order and latches that requester's payload. It then sequences a framed packet into `uart_tx` one byte at a time over a send/busy handshake. The block sits in `top` between the flight-loop producers and the debug `uart_tx` instance.

## Interface
Parameters:
- NUM_SRC, 4: number of requesters, 2..16.
- PAYLOAD_BYTES, 4: payload bytes per frame, 1..16.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_SRC  per-source request, level.
- payload  in  NUM_SRC*PAYLOAD_BYTES*8  flattened payloads. Source i occupies bits [(i+1)*PAYLOAD_BYTES*8-1 : i*PAYLOAD_BYTES*8]. Byte 0 is the most-significant byte of each slice.
- grant  out  NUM_SRC  one-hot, one-cycle pulse; marks the cycle the payload is latched.
- tx_send  out  1  one-cycle pulse to `uart_tx` send.
- tx_data  out  8  byte to `uart_tx`; stable from the tx_send cycle until tx_busy falls.
- tx_busy  in  1  `uart_tx` busy. Required to rise no later than 1 cycle after tx_send.
- frame_active  out  1  high from the grant cycle through the end of the last byte.
- frame_count  out  16  completed frames; wraps 16'hFFFF -> 0.

## Operation
- Frame format, FRAME_LEN = PAYLOAD_BYTES+3 bytes: SYNC_BYTE, ID = {4'h0, source index}, payload byte 0..PAYLOAD_BYTES-1, CHK.
- CHK = XOR of the ID byte and all payload bytes. SYNC_BYTE is excluded.
- States:
  - IDLE: if any req bit is set, the round-robin winner is chosen. Search starts at (last_grant+1) mod NUM_SRC and wraps. On that edge: grant[winner] is set, the winner's payload and ID are latched, byte_idx = 0, and the state goes to SEND. If no req bit is set, the state stays IDLE.
  - SEND: tx_send = 1 for one cycle, tx_data = frame byte[byte_idx]. Next state is SETTLE.
  - SETTLE: exactly one cycle, ignores tx_busy. Next state is WAIT_DONE.
  - WAIT_DONE: hold while tx_busy = 1. When tx_busy = 0:
    - if byte_idx = FRAME_LEN-1: frame_count is incremented, last_grant = winner, state returns to IDLE;
    - otherwise byte_idx is incremented and the state goes to SEND.
- The running checksum accumulates as bytes are issued. The CHK byte equals the accumulated value, not a recomputation.
- Sources are sampled only in IDLE.
  - A req that is still high after its grant is a new request.
  - A req that drops before being granted is lost silently.
- Payload inputs may change at any time after the grant cycle. The latched values are the ones transmitted.
- Granting is non-preemptive: a frame always completes unless reset is asserted.

## Timing
- Reset values: grant = 0, tx_send = 0, tx_data = 8'h00, frame_active = 0, frame_count = 0, state = IDLE, last_grant = NUM_SRC-1 (so source 0 has first priority), checksum = 0, byte_idx = 0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously) and the frame is abandoned. frame_count is not incremented.
- All outputs are registered.
- req sampled high at edge N: grant high in cycle N..N+1, first tx_send in cycle N+1..N+2.
- Per-byte overhead beyond `uart_tx` busy time: 3 cycles (SEND, SETTLE, the WAIT_DONE exit). A new frame can start 1 cycle after the previous frame ends (the IDLE cycle).
- tx_send never asserts while tx_busy = 1. Exactly FRAME_LEN tx_send pulses are issued per frame.
- frame_active rises with grant and falls on the edge that returns the state to IDLE.

## Test plan
- Single frame: after reset, req = 4'b0100 with source 2 payload 32'h11223344, bench `uart_tx` model with a 40-cycle busy -> bytes A5 02 11 22 33 44 46; grant = 4'b0100 for exactly one cycle; frame_count = 1; 7 tx_send pulses.
- All four sources requesting from reset and held high -> grant order 0,1,2,3,0; frame_count = 4 after four frames; every frame's ID matches its grant.
- Sources 0 and 3 requesting continuously, last_grant = 0 -> grant sequence 3,0,3,0; source 1 raised mid-frame is granted before 3 when next in order.
- Slow UART: tx_busy held for 1600 cycles per byte with a 1-cycle rise delay -> no tx_send while busy; tx_data constant throughout busy; 7 pulses total.
- rst_n low for 2 cycles after the third byte of a frame -> tx_send, grant and frame_active go to 0 at once; frame_count stays 0; the next frame restarts with A5 from source 0.
- Payload changed to 32'hFFFFFFFF one cycle after grant -> original latched bytes and CHK 46 are transmitted.
